alu_seq_exec: RTL and testbench



---
 rtl/alu_seq_exec_pkg.sv | 28 ++
 rtl/alu_seq_exec_if.sv | 26 ++
 rtl/alu_seq_exec_alu_comb_ops.sv | 28 ++
 rtl/alu_seq_exec.sv | 92 +++++++++
 tb/tb_alu_seq_exec.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_exec_pkg.sv
// Shared constants for the sequential execute unit: op codes, FSM state
// encodings and the datapath width.
package alu_seq_exec_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_LT   = 4'h8;
    localparam logic [3:0] ALU_GE   = 4'h9;
    localparam logic [3:0] ALU_LTU  = 4'hA;
    localparam logic [3:0] ALU_GEU  = 4'hB;

    localparam logic [1:0] ALU_S_IDLE  = 2'd0;
    localparam logic [1:0] ALU_S_SHIFT = 2'd1;
    localparam logic [1:0] ALU_S_DONE  = 2'd2;

    function automatic logic is_shift_op(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_seq_exec_if.sv
// Operation request / result handshake bundle between the decoder stage
// (master) and the execute unit (slave).
interface alu_seq_exec_if;
    import alu_seq_exec_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output in_valid, alu_control, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, alu_control, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero
    );

endinterface

// File: rtl/alu_seq_exec_alu_comb_ops.sv
// Pure combinational single-cycle ALU ops; shift codes and undefined
// codes produce 0 here (shifts are handled by the iterative shifter).
module alu_comb_ops
    import alu_seq_exec_pkg::*;
(
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = '0;
        unique case (alu_control)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_LT:  result = XLEN'($signed(a) <  $signed(b));
            ALU_GE:  result = XLEN'($signed(a) >= $signed(b));
            ALU_LTU: result = XLEN'(a <  b);
            ALU_GEU: result = XLEN'(a >= b);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Sequential execute unit: single-cycle logic/arith/compare ops, shifts
// iterated one bit per cycle with in_ready held low while shifting.
module alu_seq_exec
    import alu_seq_exec_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    alu_seq_exec_if.slave bus
);

    logic [1:0]      state;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] acc_next;
    logic [4:0]      cnt;
    logic [3:0]      shift_code;
    logic [XLEN-1:0] res_q;
    logic            zero_q;
    logic [XLEN-1:0] comb_res;
    logic [XLEN-1:0] imm_res;
    logic [4:0]      shamt;
    logic            accept;
    logic            start_shift;

    alu_comb_ops u_comb (
        .alu_control (bus.alu_control),
        .a           (bus.op_a),
        .b           (bus.op_b),
        .result      (comb_res)
    );

    assign bus.in_ready  = (state == ALU_S_IDLE) || ((state == ALU_S_DONE) && bus.out_ready);
    assign bus.out_valid = (state == ALU_S_DONE);
    assign bus.result    = res_q;
    assign bus.zero      = zero_q;

    assign shamt       = bus.op_b[4:0];
    assign accept      = bus.in_valid && bus.in_ready;
    assign start_shift = is_shift_op(bus.alu_control) && (shamt != 5'd0);
    // A zero-distance shift completes immediately with op_a unchanged.
    assign imm_res     = is_shift_op(bus.alu_control) ? bus.op_a : comb_res;

    always_comb begin
        acc_next = acc;
        unique case (shift_code)
            ALU_SLL: acc_next = {acc[XLEN-2:0], 1'b0};
            ALU_SRL: acc_next = {1'b0, acc[XLEN-1:1]};
            ALU_SRA: acc_next = {acc[XLEN-1], acc[XLEN-1:1]};
            default: acc_next = acc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ALU_S_IDLE;
            acc        <= '0;
            cnt        <= '0;
            shift_code <= '0;
            res_q      <= '0;
            zero_q     <= 1'b0;
        end else begin
            unique case (state)
                ALU_S_IDLE, ALU_S_DONE: begin
                    if (accept) begin
                        if (start_shift) begin
                            acc        <= bus.op_a;
                            cnt        <= shamt;
                            shift_code <= bus.alu_control;
                            state      <= ALU_S_SHIFT;
                        end else begin
                            res_q  <= imm_res;
                            zero_q <= (imm_res == '0);
                            state  <= ALU_S_DONE;
                        end
                    end else if ((state == ALU_S_DONE) && bus.out_ready) begin
                        state <= ALU_S_IDLE;
                    end
                end
                ALU_S_SHIFT: begin
                    acc <= acc_next;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        res_q  <= acc_next;
                        zero_q <= (acc_next == '0);
                        state  <= ALU_S_DONE;
                    end
                end
                default: state <= ALU_S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed and randomised self-checking bench for alu_seq_exec.
module tb_alu_seq_exec;
    import alu_seq_exec_pkg::*;

    localparam int unsigned N_RAND = 3000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_exec_if bus();

    alu_seq_exec dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid    = 1'b1;
        bus.alu_control = code;
        bus.op_a        = a;
        bus.op_b        = b;
    endtask

    task automatic wait_out(output int unsigned cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 64) begin
            tick();
            cyc++;
        end
    endtask

    // Accept one op with out_ready=1, measure cycles from accept to out_valid, then retire it.
    task automatic run_op(input string tag, input logic [3:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] want, input int unsigned lat);
        int unsigned cyc;
        bus.out_ready = 1'b1;
        set_op(code, a, b);
        #1;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        wait_out(cyc);
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_result"}, bus.result, want);
        check({tag, "_zero"}, 32'(bus.zero), 32'(want == 32'd0));
        tick();
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return a << b[4:0];
            4'h6: return a >> b[4:0];
            4'h7: return 32'($signed(a) >>> b[4:0]);
            4'h8: return {31'd0, $signed(a) < $signed(b)};
            4'h9: return {31'd0, $signed(a) >= $signed(b)};
            4'hA: return {31'd0, a < b};
            4'hB: return {31'd0, a >= b};
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] want;
        int unsigned issued;
        int unsigned cyc;
        logic took;

        bus.in_valid = 1'b0;
        bus.alu_control = '0;
        bus.op_a = '0;
        bus.op_b = '0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_zero", 32'(bus.zero), 32'd0);
        #20 rst_n = 1'b1;
        tick();
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // Back-to-back single-cycle ops under continuous out_ready.
        bus.out_ready = 1'b1;
        set_op(ALU_ADD, 32'd7, 32'd5);
        tick();
        check("b2b_add", bus.result, 32'd12);
        check("b2b_add_zero", 32'(bus.zero), 32'd0);
        check("b2b_add_valid", 32'(bus.out_valid), 32'd1);
        set_op(ALU_SUB, 32'd5, 32'd7);
        tick();
        check("b2b_sub", bus.result, 32'hFFFF_FFFE);
        check("b2b_sub_zero", 32'(bus.zero), 32'd0);
        set_op(ALU_LT, 32'hFFFF_FFFF, 32'd1);
        tick();
        check("b2b_lt", bus.result, 32'd1);
        check("b2b_lt_zero", 32'(bus.zero), 32'd0);
        bus.in_valid = 1'b0;
        tick();
        check("b2b_idle_valid", 32'(bus.out_valid), 32'd0);

        run_op("sra4", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 4);
        run_op("srl4", ALU_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 4);
        run_op("sll0", ALU_SLL, 32'd3, 32'd0, 32'd3, 0);
        run_op("sll31", ALU_SLL, 32'd1, 32'h0000_003F, 32'h8000_0000, 31);
        run_op("srl_bhi", ALU_SRL, 32'hF000_0000, 32'h0000_0024, 32'h0F00_0000, 4);
        run_op("geu", ALU_GEU, 32'h8000_0000, 32'd1, 32'd1, 0);
        run_op("ge", ALU_GE, 32'h8000_0000, 32'd1, 32'd0, 0);
        run_op("ltu", ALU_LTU, 32'h8000_0000, 32'd1, 32'd0, 0);
        run_op("xor", ALU_XOR, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, 0);
        run_op("and", ALU_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 0);
        run_op("or", ALU_OR, 32'hF000_0001, 32'h0000_0100, 32'hF000_0101, 0);
        run_op("undef", 4'hE, 32'd5, 32'd6, 32'd0, 0);

        // Backpressure: result held, new request ignored until handshake.
        bus.out_ready = 1'b0;
        set_op(ALU_SUB, 32'd9, 32'd9);
        tick();
        set_op(ALU_ADD, 32'd1, 32'd2);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_result", bus.result, 32'd0);
            check("bp_zero", 32'(bus.zero), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check("bp_next_result", bus.result, 32'd3);
        check("bp_next_zero", 32'(bus.zero), 32'd0);
        bus.in_valid = 1'b0;
        tick();
        check("bp_idle", 32'(bus.out_valid), 32'd0);

        // Reset mid-shift discards the op and clears the output register.
        set_op(ALU_SLL, 32'd1, 32'd20);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mid_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_result", bus.result, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rel_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rel_valid", 32'(bus.out_valid), 32'd0);
        run_op("sll20", ALU_SLL, 32'd1, 32'd20, 32'h0010_0000, 20);

        // Random traffic against the reference model, in order.
        issued = 0;
        cyc = 0;
        bus.in_valid = 1'b0;
        while ((issued < N_RAND || exp_q.size() != 0) && cyc < 80000) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!bus.in_valid && issued < N_RAND && $urandom_range(0, 3) != 0) begin
                set_op(4'($urandom_range(0, 15)),
                       ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom(),
                       ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom());
            end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_extra_result", 32'd1, 32'd0);
                end else begin
                    want = exp_q.pop_front();
                    check("rnd_result", bus.result, want);
                    check("rnd_zero", 32'(bus.zero), 32'(want == 32'd0));
                end
            end
            took = bus.in_valid && bus.in_ready;
            if (took) begin
                exp_q.push_back(ref_alu(bus.alu_control, bus.op_a, bus.op_b));
                issued++;
            end
            tick();
            cyc++;
            if (took) bus.in_valid = 1'b0;
        end
        check("rnd_issued", issued, N_RAND);
        check("rnd_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
